// File: rtl/push_sequencer_if.sv
// Handshake and feedback bundle between push_sequencer, its controller and the BCD counter.
interface push_sequencer_if;
    logic       i_Start;
    logic [3:0] i_Tgt_Ones;
    logic [3:0] i_Tgt_Tens;
    logic [3:0] i_Cur_Ones;
    logic [3:0] i_Cur_Tens;
    logic [1:0] o_Push;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Err;

    modport master (
        output i_Start, i_Tgt_Ones, i_Tgt_Tens, i_Cur_Ones, i_Cur_Tens,
        input  o_Push, o_Busy, o_Done, o_Err
    );

    modport slave (
        input  i_Start, i_Tgt_Ones, i_Tgt_Tens, i_Cur_Ones, i_Cur_Tens,
        output o_Push, o_Busy, o_Done, o_Err
    );
endinterface

// File: rtl/push_sequencer.sv
// Presses the BCD counter's active-low up/down buttons until its value equals the target.
// Optional PUSH_SEQ_ABORT_EN adds i_Abort (released gap, then error pulse).
module push_sequencer #(
    parameter int unsigned P_PRESS    = 2,
    parameter int unsigned P_GAP      = 2,
    parameter int unsigned P_MAX_PUSH = 60
) (
    input  logic           i_Clk,
    input  logic           i_Rst,
`ifdef PUSH_SEQ_ABORT_EN
    input  logic           i_Abort,
`endif
    push_sequencer_if.slave bus
);

    localparam int unsigned LP_PH  = (P_PRESS > P_GAP) ? P_PRESS : P_GAP;
    localparam int unsigned LP_PHW = $clog2(LP_PH + 1);
    localparam int unsigned LP_CW  = $clog2(P_MAX_PUSH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_PRESS, S_GAP, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t            r_State, w_State_Nxt;
    logic [3:0]        r_Tgt_Ones, r_Tgt_Tens;
    logic              r_Dir_Up, w_Dir_Nxt;
    logic [LP_PHW-1:0] r_Ph, w_Ph_Nxt;
    logic [LP_CW-1:0]  r_Cnt, w_Cnt_Nxt;
    logic              r_Abort_Pend, w_Abort_Nxt;
    logic [1:0]        r_Push;
    logic              r_Busy, r_Done, r_Err;

    logic [6:0]        w_T, w_C, w_D;
    logic              w_Tgt_Bad, w_Match, w_Abort_Req;

`ifdef PUSH_SEQ_ABORT_EN
    assign w_Abort_Req = i_Abort && (r_State != S_IDLE);
`else
    assign w_Abort_Req = 1'b0;
`endif

    // Shortest-direction distance modulo 100; the +100 branch covers T < C.
    assign w_T       = 7'(r_Tgt_Tens) * 7'd10 + 7'(r_Tgt_Ones);
    assign w_C       = 7'(bus.i_Cur_Tens) * 7'd10 + 7'(bus.i_Cur_Ones);
    assign w_D       = (w_T >= w_C) ? (w_T - w_C) : (w_T + 7'd100 - w_C);
    assign w_Tgt_Bad = (r_Tgt_Ones > 4'd9) || (r_Tgt_Tens > 4'd9);
    assign w_Match   = (bus.i_Cur_Ones == r_Tgt_Ones) && (bus.i_Cur_Tens == r_Tgt_Tens);

    always_comb begin
        w_State_Nxt = r_State;
        w_Dir_Nxt   = r_Dir_Up;
        w_Ph_Nxt    = r_Ph;
        w_Cnt_Nxt   = r_Cnt;
        w_Abort_Nxt = r_Abort_Pend;
        case (r_State)
            S_IDLE: begin
                w_Cnt_Nxt   = '0;
                w_Abort_Nxt = 1'b0;
                if (bus.i_Start) w_State_Nxt = S_CALC;
            end
            S_CALC: begin
                if (w_Tgt_Bad) begin
                    w_State_Nxt = S_ERR;
                end else if (w_D == 7'd0) begin
                    w_State_Nxt = S_DONE;
                end else begin
                    w_State_Nxt = S_PRESS;
                    w_Dir_Nxt   = (w_D <= 7'd50);
                    w_Ph_Nxt    = LP_PHW'(1);
                    w_Cnt_Nxt   = r_Cnt + LP_CW'(1);
                end
            end
            S_PRESS: begin
                if (r_Ph == LP_PHW'(P_PRESS)) begin
                    w_State_Nxt = S_GAP;
                    w_Ph_Nxt    = LP_PHW'(1);
                end else begin
                    w_Ph_Nxt = r_Ph + LP_PHW'(1);
                end
            end
            S_GAP: begin
                if (r_Ph == LP_PHW'(P_GAP)) begin
                    w_State_Nxt = r_Abort_Pend ? S_ERR : S_CHECK;
                end else begin
                    w_Ph_Nxt = r_Ph + LP_PHW'(1);
                end
            end
            S_CHECK: begin
                if (w_Match) begin
                    w_State_Nxt = S_DONE;
                end else if (r_Cnt == LP_CW'(P_MAX_PUSH)) begin
                    w_State_Nxt = S_ERR;
                end else begin
                    w_State_Nxt = S_PRESS;
                    w_Ph_Nxt    = LP_PHW'(1);
                    w_Cnt_Nxt   = r_Cnt + LP_CW'(1);
                end
            end
            S_DONE:  w_State_Nxt = S_IDLE;
            S_ERR:   w_State_Nxt = S_IDLE;
            default: w_State_Nxt = S_IDLE;
        endcase

        // Abort forces one full release gap before the error exit; an abort inside GAP keeps its timing.
        if (w_Abort_Req) begin
            if (r_State == S_CALC || r_State == S_PRESS || r_State == S_CHECK) begin
                w_State_Nxt = S_GAP;
                w_Ph_Nxt    = LP_PHW'(1);
                w_Abort_Nxt = 1'b1;
            end else if (r_State == S_GAP) begin
                w_Abort_Nxt = 1'b1;
                if (w_State_Nxt == S_CHECK) w_State_Nxt = S_ERR;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State      <= S_IDLE;
            r_Tgt_Ones   <= '0;
            r_Tgt_Tens   <= '0;
            r_Dir_Up     <= 1'b0;
            r_Ph         <= '0;
            r_Cnt        <= '0;
            r_Abort_Pend <= 1'b0;
            r_Push       <= 2'b11;
            r_Busy       <= 1'b0;
            r_Done       <= 1'b0;
            r_Err        <= 1'b0;
        end else begin
            r_State      <= w_State_Nxt;
            r_Dir_Up     <= w_Dir_Nxt;
            r_Ph         <= w_Ph_Nxt;
            r_Cnt        <= w_Cnt_Nxt;
            r_Abort_Pend <= w_Abort_Nxt;
            if (r_State == S_IDLE && bus.i_Start) begin
                r_Tgt_Ones <= bus.i_Tgt_Ones;
                r_Tgt_Tens <= bus.i_Tgt_Tens;
            end
            // Outputs registered from next state so they align with the state they describe.
            r_Push <= (w_State_Nxt == S_PRESS) ? (w_Dir_Nxt ? 2'b01 : 2'b10) : 2'b11;
            r_Busy <= (w_State_Nxt != S_IDLE);
            r_Done <= (w_State_Nxt == S_DONE);
            r_Err  <= (w_State_Nxt == S_ERR);
        end
    end

    assign bus.o_Push = r_Push;
    assign bus.o_Busy = r_Busy;
    assign bus.o_Done = r_Done;
    assign bus.o_Err  = r_Err;

endmodule

// File: tb/tb_push_sequencer.sv
// Bench for push_sequencer: counter model on the push lines, distance-based reference model.
module tb_push_sequencer;
    localparam int P_PRESS    = 2;
    localparam int P_GAP      = 2;
    localparam int P_MAX_PUSH = 60;
    localparam int K          = P_PRESS + P_GAP + 1;
    localparam int LIMIT      = 2 + P_MAX_PUSH * K + 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int   cnt = 0;
    int   ld_val = 0;
    bit   ld_req = 1'b0;
    bit   frozen = 1'b0;
    logic [1:0] prev_push;
`ifdef PUSH_SEQ_ABORT_EN
    logic abort_r = 1'b0;
`endif

    push_sequencer_if bus();

    push_sequencer #(
        .P_PRESS   (P_PRESS),
        .P_GAP     (P_GAP),
        .P_MAX_PUSH(P_MAX_PUSH)
    ) dut (
        .i_Clk  (clk),
        .i_Rst  (rst_n),
`ifdef PUSH_SEQ_ABORT_EN
        .i_Abort(abort_r),
`endif
        .bus    (bus)
    );

    // Counter model: counts once per press (released -> pressed transition), wrapping mod 100.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_push <= 2'b11;
        end else begin
            prev_push <= bus.o_Push;
            if (ld_req) cnt <= ld_val;
            else if (!frozen && prev_push == 2'b11 && bus.o_Push == 2'b01) cnt <= (cnt + 1) % 100;
            else if (!frozen && prev_push == 2'b11 && bus.o_Push == 2'b10) cnt <= (cnt + 99) % 100;
        end
    end

    assign bus.i_Cur_Ones = 4'(cnt % 10);
    assign bus.i_Cur_Tens = 4'(cnt / 10);

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_seq(input int cur, input int tt, input int to, input bit frz,
                           input int abort_at, input bit poke);
        bit   bad, exp_err, exp_up, got_err;
        int   tval, d, exp_n, exp_k, presses, width, gap, end_k, pulses, ka, k;
        logic [1:0] p, prev;

        @(negedge clk);
        ld_val = cur; ld_req = 1'b1; frozen = frz;
        @(negedge clk);
        ld_req = 1'b0;

        bad  = (tt > 9) || (to > 9);
        tval = tt * 10 + to;
        d    = (((tval - cur) % 100) + 100) % 100;
        exp_up = (d <= 50);
        if (bad)          begin exp_err = 1; exp_n = 0; end
        else if (d == 0)  begin exp_err = 0; exp_n = 0; end
        else if (frz)     begin exp_err = 1; exp_n = P_MAX_PUSH; end
        else              begin exp_err = 0; exp_n = exp_up ? d : 100 - d; end
        exp_k = 1 + exp_n * K;
        if (abort_at > 0) begin exp_err = 1; exp_n = abort_at; end

        bus.i_Tgt_Tens = 4'(tt);
        bus.i_Tgt_Ones = 4'(to);
        bus.i_Start    = 1'b1;
        @(posedge clk);
        #1 bus.i_Start = 1'b0;

        presses = 0; width = 0; gap = 0; end_k = -1; pulses = 0; ka = -1;
        got_err = 1'b0; prev = 2'b11;
        for (k = 0; k < LIMIT; k++) begin
            @(negedge clk);
            p = bus.o_Push;
            if (k == 0) chk("busy_rise", int'(bus.o_Busy), 1);
            chk("push_not_00", int'(p == 2'b00), 0);
            if (p != 2'b11) begin
                if (prev == 2'b11) begin
                    presses++;
                    chk("press_dir", int'(p), exp_up ? 1 : 2);
                    if (presses > 1) chk("gap_len", int'(gap >= P_GAP), 1);
                    width = 0;
                    if (presses == abort_at) begin
                        ka = k;
`ifdef PUSH_SEQ_ABORT_EN
                        abort_r = 1'b1;
`endif
                    end
                end
                width++;
            end else begin
                if (prev != 2'b11) begin
                    gap = 0;
                    if (!(abort_at > 0 && presses == abort_at)) chk("press_len", width, P_PRESS);
                end
                gap++;
            end
            if (ka >= 0 && k == ka + 1) begin
`ifdef PUSH_SEQ_ABORT_EN
                abort_r = 1'b0;
`endif
                chk("abort_release", int'(p), 3);
                exp_k = ka + P_GAP + 1;
            end
            if (poke && k == 2) begin
                bus.i_Start = 1'b1; bus.i_Tgt_Tens = 4'd0; bus.i_Tgt_Ones = 4'd1;
            end
            if (poke && k == 3) bus.i_Start = 1'b0;
            if (bus.o_Done || bus.o_Err) begin
                pulses++;
                if (end_k < 0) begin end_k = k; got_err = bus.o_Err; end
            end
            if (end_k >= 0 && !bus.o_Busy) begin
                chk("busy_fall", k, end_k + 1);
                break;
            end
            prev = p;
        end
        if (end_k < 0) chk("timeout", k, -1);
        chk("end_kind_err", int'(got_err), int'(exp_err));
        chk("end_latency", end_k, exp_k);
        chk("press_count", presses, exp_n);
        chk("pulse_cycles", pulses, 1);
        if (!frz && !bad && abort_at == 0) chk("final_value", cnt, tval);
        chk("push_idle", int'(bus.o_Push), 3);
    endtask

    initial begin
        int c, t;
        bus.i_Start = 1'b0; bus.i_Tgt_Ones = '0; bus.i_Tgt_Tens = '0;
        #12;
        chk("rst_push", int'(bus.o_Push), 3);
        chk("rst_busy", int'(bus.o_Busy), 0);
        chk("rst_done", int'(bus.o_Done), 0);
        chk("rst_err",  int'(bus.o_Err), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_push", int'(bus.o_Push), 3);

        run_seq(7, 1, 2, 0, 0, 0);
        run_seq(3, 9, 7, 0, 0, 0);
        run_seq(20, 7, 0, 0, 0, 1);
        run_seq(45, 4, 5, 0, 0, 0);
        run_seq(30, 0, 12, 0, 0, 0);
        run_seq(5, 0, 6, 1, 0, 0);
        run_seq(99, 0, 1, 0, 0, 0);
        run_seq(0, 9, 9, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            c = int'($urandom_range(0, 99));
            t = int'($urandom_range(0, 99));
            run_seq(c, t / 10, t % 10, 0, 0, 0);
        end

        // Reset mid-press: lines release at once and the FSM is idle afterwards.
        @(negedge clk);
        ld_val = 10; ld_req = 1'b1; frozen = 1'b0;
        @(negedge clk);
        ld_req = 1'b0;
        bus.i_Tgt_Tens = 4'd3; bus.i_Tgt_Ones = 4'd0; bus.i_Start = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        for (int i = 0; i < 20 && bus.o_Push == 2'b11; i++) @(negedge clk);
        chk("reach_press", int'(bus.o_Push), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_push", int'(bus.o_Push), 3);
        chk("midrst_busy", int'(bus.o_Busy), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_rst_idle_busy", int'(bus.o_Busy), 0);
        chk("after_rst_idle_push", int'(bus.o_Push), 3);
        run_seq(12, 1, 5, 0, 0, 0);

`ifdef PUSH_SEQ_ABORT_EN
        run_seq(10, 2, 5, 0, 3, 0);
        run_seq(40, 4, 9, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/push_sequencer.md
Name: push_sequencer

Overview:
- Drives the active-low two-button push interface of the two-digit BCD up/down counter: the producer end of that interface, replacing the human pressing buttons.
- Takes a two-digit BCD target and emits single press/release pulses on o_Push until the counter's fed-back value equals the target.
- Each step moves in the shortest direction modulo 100.
- Sits between control logic (or a test harness) and the counter's push input; reads the counter's digit outputs back as feedback.

Parameters:
- P_PRESS, 2, cycles a button is held low per push (min 1)
- P_GAP, 2, cycles both buttons are held released after each push (min 1); guarantees the counter sees a release before the next press
- P_MAX_PUSH, 60, push budget per sequence before the sequence is declared failed

Ports:
- i_Clk  input  1  clock
- i_Rst  input  1  asynchronous reset, active-low
- i_Start  input  1  one-cycle start pulse; ignored unless idle
- i_Tgt_Ones  input  4  target units digit, BCD
- i_Tgt_Tens  input  4  target tens digit, BCD
- i_Cur_Ones  input  4  counter units digit, fed back
- i_Cur_Tens  input  4  counter tens digit, fed back
- o_Push  output  2  active-low push lines; bit1 = up, bit0 = down; 2'b11 = released
- o_Busy  output  1  high from accepted start until the DONE/ERR state exits
- o_Done  output  1  one-cycle pulse: counter reached the target
- o_Err  output  1  one-cycle pulse: bad target or push budget exhausted

Behaviour:
- Reset: the following values apply while i_Rst is low and on its release. Reset is asynchronous and may occur mid-sequence; no partial push survives it.
  - o_Push = 2'b11
  - o_Busy = 0, o_Done = 0, o_Err = 0
  - state = IDLE
  - push count = 0
- States: IDLE, CALC, PRESS, GAP, CHECK, DONE, ERR.
- IDLE:
  - o_Push = 11.
  - On i_Start, latch the target digits and go to CALC.
  - o_Busy rises on the cycle after i_Start is sampled.
- CALC (one cycle):
  - If either latched target digit is > 9, go to ERR.
  - Otherwise form T = 10*tens + ones and C = 10*cur_tens + cur_ones.
  - Compute D = (T - C) mod 100, in 7-bit arithmetic with a +100 correction when negative.
  - If D == 0, go to DONE with no push.
  - If D <= 50, direction = up (a tie at D = 50 resolves to up). Otherwise direction = down.
  - Direction is latched for the rest of the sequence.
- PRESS:
  - Drive o_Push = 2'b01 (up) or 2'b10 (down) for exactly P_PRESS cycles.
  - Increment the push count on entry.
  - Then go to GAP.
- GAP: o_Push = 11 for exactly P_GAP cycles, then go to CHECK.
- CHECK (one cycle):
  - If current digits equal the latched target, go to DONE.
  - Else if push count == P_MAX_PUSH, go to ERR.
  - Else go to PRESS.
  - Direction is not recomputed.
- DONE: o_Done = 1 for one cycle, o_Busy falls the next cycle, return to IDLE.
- ERR: o_Err = 1 for one cycle, o_Busy falls the next cycle, return to IDLE.
- Push line rules:
  - Never drive o_Push = 00.
  - Never press on two consecutive cycles without an intervening release of at least P_GAP cycles.
- Wrap-around:
  - Up from 99 relies on the counter wrapping to 00.
  - Down from 00 relies on the counter wrapping to 99.
  - The sequencer treats both as a normal step.
- Invalid feedback: a feedback digit > 9 is not checked. The sequence runs until it matches or the budget is exhausted.
- Start while busy: ignored; latched target digits are unchanged.
- Target inputs may change while busy without effect.
- All outputs are registered.

Optional Feature:
- Macro: PUSH_SEQ_ABORT_EN.
- When defined, adds port i_Abort (input, 1 bit, active-high, synchronous).
- i_Abort sampled in any non-IDLE state:
  - If in PRESS, o_Push returns to 11 on the next cycle.
  - The FSM then passes through one GAP period so the counter sees a release.
  - It then enters ERR (o_Err pulse) and returns to IDLE.
- When not defined, the port does not exist and sequences only end via DONE or ERR.

Test Plan:
- Cur 07, target 12, P_PRESS = 2, P_GAP = 2, counter model attached -> exactly 5 up presses, each 2 cycles low with 2-cycle gaps; o_Done pulse after counter shows 12; o_Err never asserted.
- Cur 03, target 97 -> down direction chosen (D = 94); 6 down presses through the 00 -> 99 wrap; o_Done pulse.
- Cur 20, target 70 (D = 50 tie) -> up chosen; 50 presses; o_Done pulse. Cur 45, target 45 -> o_Done 2 cycles after start, zero presses.
- Target ones = 4'hC -> o_Err pulse after CALC; o_Push stays 11 throughout.
- Feedback frozen at 05, target 06 -> 60 presses, then o_Err pulse; o_Busy falls. Reset asserted mid-PRESS -> o_Push = 11 immediately and FSM in IDLE.
- With PUSH_SEQ_ABORT_EN, i_Abort during the 3rd press -> o_Push releases next cycle, held 11 for P_GAP cycles, then o_Err pulse; i_Start asserted while busy is ignored.
